mul_share_ctrl: RTL and testbench

Sequencing controller and two-way arbiter for the shared repeated-addition multiplier datapath (registers A, B, accumulator P; P = A × B computed by adding A into P while decrementing B to zero). Two requesters compete for the datapath. The block grants one requester round-robin, drives the datapath load/clear/decrement strobes and the operand-select mux, and returns a per-requester done pulse. A watchdog bounds the add loop and flags an error if B never reaches zero.

---
 rtl/mul_share_ctrl.sv | 149 ++++++++++++++
 tb/tb_mul_share_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_ctrl
// Description : Round-robin two-way arbiter and sequencer for a shared
//               repeated-addition multiplier datapath (A, B, accumulator P).
//               Computes P = A * B by adding A into P while decrementing B
//               to zero. A watchdog bounds the add loop and flags an error
//               if B never reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_ctrl #(
  parameter int ITER_W   = 8,
  // Must not exceed 2**ITER_W - 1 so the iteration counter never wraps.
  parameter int MAX_ITER = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic eqz,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic ld_a,
  output logic ld_b,
  output logic clr_p,
  output logic ld_p,
  output logic dec,
  output logic busy,
  output logic done0,
  output logic done1,
  output logic err
);

  localparam logic [ITER_W-1:0] MAX_CNT  = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              own;       // requester currently holding the datapath
  logic              own_nx;
  logic              ptr;       // requester with priority on a tie
  logic              ptr_nx;
  logic [ITER_W-1:0] iter;      // add cycles issued in the current operation
  logic [ITER_W-1:0] iter_nx;
  logic              err_r;     // watchdog outcome of the current operation
  logic              err_nx;

  // State, ownership, priority pointer, iteration count and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      own   <= 1'b0;
      ptr   <= 1'b0;
      iter  <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nx;
      own   <= own_nx;
      ptr   <= ptr_nx;
      iter  <= iter_nx;
      err_r <= err_nx;
    end
  end

  // Next-state logic and datapath strobes; strobes are Moore except ld_p/dec,
  // which also depend on eqz and the watchdog count while in ADD.
  always_comb begin
    state_nx = state;
    own_nx   = own;
    ptr_nx   = ptr;
    iter_nx  = iter;
    err_nx   = err_r;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    sel      = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    clr_p    = 1'b0;
    ld_p     = 1'b0;
    dec      = 1'b0;
    busy     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    err      = 1'b0;

    // Ownership is visible for the whole operation, LOAD through DONE.
    if (state != S_IDLE) begin
      gnt0 = ~own;
      gnt1 = own;
      sel  = own;
      busy = 1'b1;
    end

    case (state)
      S_IDLE: begin
        // Requests are only sampled here; a tie goes to the pointer.
        if (req0 || req1) begin
          own_nx   = (req0 && req1) ? ptr : req1;
          state_nx = S_LOAD;
        end
      end

      S_LOAD: begin
        ld_a     = 1'b1;
        ld_b     = 1'b1;
        clr_p    = 1'b1;
        iter_nx  = '0;
        state_nx = S_ADD;
      end

      S_ADD: begin
        if (eqz) begin
          err_nx   = 1'b0;
          state_nx = S_DONE;
        end else if (iter == MAX_CNT) begin
          err_nx   = 1'b1;
          state_nx = S_DONE;
        end else begin
          ld_p    = 1'b1;
          dec     = 1'b1;
          iter_nx = iter + ITER_ONE;
        end
      end

      S_DONE: begin
        done0    = ~own;
        done1    = own;
        err      = err_r;
        // Hand priority to the other requester for the next tie.
        ptr_nx   = ~own;
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_ctrl
// Description : Self-checking bench for mul_share_ctrl with a behavioural
//               A/B/P datapath model and a completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_ctrl;

  localparam int MAXI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic eqz;
  logic gnt0, gnt1, sel, ld_a, ld_b, clr_p, ld_p, dec, busy, done0, done1, err;

  // Operand sources and datapath model
  logic [7:0]  a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
  logic [7:0]  A, B;
  logic [15:0] P;
  bit          eqz_stuck = 1'b0;

  typedef struct packed {
    logic        who;
    logic        err;
    logic [15:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;

  mul_share_ctrl #(
    .ITER_W  (8),
    .MAX_ITER(MAXI)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .eqz  (eqz),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .sel  (sel),
    .ld_a (ld_a),
    .ld_b (ld_b),
    .clr_p(clr_p),
    .ld_p (ld_p),
    .dec  (dec),
    .busy (busy),
    .done0(done0),
    .done1(done1),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Shared datapath driven by the controller strobes
  always @(posedge clk) begin
    if (rst) begin
      A <= 8'd0;
      B <= 8'd0;
      P <= 16'd0;
    end else begin
      if (ld_a)  A <= sel ? a1 : a0;
      if (ld_b)  B <= sel ? b1 : b0;
      if (clr_p) P <= 16'd0;
      if (ld_p)  P <= P + {8'd0, A};
      if (dec)   B <= B - 8'd1;
    end
  end

  assign eqz = eqz_stuck ? 1'b0 : (B == 8'd0);

  function automatic logic [11:0] outs();
    return {gnt0, gnt1, sel, ld_a, ld_b, clr_p, ld_p, dec, busy, done0, done1, err};
  endfunction

  // Expected output vector at cycle k of an operation whose add loop runs n times
  function automatic logic [11:0] exp_vec(input int who, input int n, input int k, input bit e);
    logic g0, g1, s, la, lb, cp, lp, dc, bz, d0, d1, er;
    {g0, g1, s, la, lb, cp, lp, dc, bz, d0, d1, er} = 12'd0;
    if (k >= 1 && k <= n + 3) begin
      g0 = (who == 0);
      g1 = (who == 1);
      s  = (who == 1);
      bz = 1'b1;
    end
    if (k == 1) begin
      la = 1'b1; lb = 1'b1; cp = 1'b1;
    end
    if (k >= 2 && k <= n + 1) begin
      lp = 1'b1; dc = 1'b1;
    end
    if (k == n + 3) begin
      d0 = (who == 0);
      d1 = (who == 1);
      er = e;
    end
    return {g0, g1, s, la, lb, cp, lp, dc, bz, d0, d1, er};
  endfunction

  // Scoreboard: every completion pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && (done0 || done1)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done: got done0=%b done1=%b, want no done", done0, done1);
      end else begin
        mon_e = sb.pop_front();
        if ({done1, done0} !== (mon_e.who ? 2'b10 : 2'b01) || err !== mon_e.err || P !== mon_e.p) begin
          failures++;
          $display("FAIL sb_result: got done1/done0=%b%b err=%b P=%0d, want who=%0d err=%b P=%0d",
                   done1, done0, err, P, mon_e.who, mon_e.err, mon_e.p);
        end
      end
    end
  end

  // Start an operation: raise a request in IDLE and check the idle cycle 0
  task automatic begin_op(input int who);
    @(posedge clk);
    #1;
    if (who == 0) req0 = 1'b1;
    else          req1 = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 12'd0) begin
      failures++;
      $display("FAIL idle_cycle0: got %b want %b", outs(), 12'd0);
    end
  endtask

  // Check cycles 1..n+4 of one operation; optionally drop requests in DONE
  task automatic check_op(input string name, input int who, input int n, input bit e, input bit drop);
    logic [11:0] act, expv;
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      act  = outs();
      expv = exp_vec(who, n, k, e);
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b want %b", name, k, act, expv);
      end
      if (k == n + 3 && drop) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    a0 = 8'd2; b0 = 8'd2; a1 = 8'd3; b1 = 8'd1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (outs() !== 12'd0) begin
        failures++;
        $display("FAIL reset_outputs: got %b want %b", outs(), 12'd0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back('{who: 1'b0, err: 1'b0, p: 16'd4});
    @(negedge clk);
    checks++;
    if (outs() !== 12'd0) begin
      failures++;
      $display("FAIL reset_release_idle: got %b want %b", outs(), 12'd0);
    end
    check_op("reset_first_grant", 0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_single();
    a0 = 8'd5; b0 = 8'd3;
    sb.push_back('{who: 1'b0, err: 1'b0, p: 16'd15});
    begin_op(0);
    check_op("single_5x3", 0, 3, 1'b0, 1'b1);
  endtask

  task automatic test_b_zero();
    a1 = 8'd9; b1 = 8'd0;
    sb.push_back('{who: 1'b1, err: 1'b0, p: 16'd0});
    begin_op(1);
    check_op("b_zero_req1", 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    a0 = 8'd3; b0 = 8'd1; a1 = 8'd6; b1 = 8'd1;
    for (int i = 0; i < 4; i++)
      sb.push_back('{who: 1'(i % 2), err: 1'b0, p: ((i % 2) != 0) ? 16'd6 : 16'd3});
    @(posedge clk);
    #1;
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check_op("contention", i % 2, 1, 1'b0, i == 3);
  endtask

  task automatic test_watchdog();
    a0 = 8'd7; b0 = 8'd3;
    eqz_stuck = 1'b1;
    sb.push_back('{who: 1'b0, err: 1'b1, p: 16'd28});
    begin_op(0);
    check_op("watchdog", 0, MAXI, 1'b1, 1'b1);
    eqz_stuck = 1'b0;
    a0 = 8'd4; b0 = 8'd2;
    sb.push_back('{who: 1'b0, err: 1'b0, p: 16'd8});
    begin_op(0);
    check_op("after_watchdog", 0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    a0 = 8'd2; b0 = 8'd10;
    begin_op(0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (outs() !== exp_vec(0, MAXI, k, 1'b0)) begin
        failures++;
        $display("FAIL reset_mid_pre cycle %0d: got %b want %b", k, outs(), exp_vec(0, MAXI, k, 1'b0));
      end
    end
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req1 = 1'b1;
    b0   = 8'd2;
    @(negedge clk);
    checks++;
    if (outs() !== exp_vec(0, MAXI, 4, 1'b0)) begin
      failures++;
      $display("FAIL reset_mid_cycle4: got %b want %b", outs(), exp_vec(0, MAXI, 4, 1'b0));
    end
    @(negedge clk);
    checks++;
    if (outs() !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid_after: got %b want %b", outs(), 12'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back('{who: 1'b0, err: 1'b0, p: 16'd4});
    @(negedge clk);
    checks++;
    if (outs() !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid_idle: got %b want %b", outs(), 12'd0);
    end
    check_op("post_reset_grant", 0, 2, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_b_zero();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending results, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish by 100000, want finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
